sobel_stream_accel: RTL and testbench



---
 rtl/sobel_stream_accel.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_sobel_stream_accel.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_accel.sv
// Streaming 3x3 Sobel edge filter: OBI register file plus OBI memory manager with line buffers.
// Optional cycle counter at offset 0x14 is built only when SOBEL_STREAM_ACCEL_PERF_EN is defined.
package sobel_stream_accel_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        aid;
   } obi_req_t;
   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        rid;
      logic        err;
   } obi_rsp_t;
   typedef obi_req_t mgr_obi_req_t;
   typedef obi_rsp_t mgr_obi_rsp_t;
   typedef obi_req_t sbr_obi_req_t;
   typedef obi_rsp_t sbr_obi_rsp_t;
endpackage

module sobel_stream_accel
   import sobel_stream_accel_pkg::*;
#(
   parameter int unsigned MaxWidth    = 640,
   parameter logic [7:0]  ThreshReset = 8'd128
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  mgr_obi_req_t obi_sbr_req_i,
   output mgr_obi_rsp_t obi_sbr_rsp_o,
   output sbr_obi_req_t obi_mgr_req_o,
   input  sbr_obi_rsp_t obi_mgr_rsp_i,
   output logic         interrupt_o
);
   localparam int unsigned LbAw   = (MaxWidth > 1) ? $clog2(MaxWidth) : 1;
   localparam logic [16:0] MaxW17 = 17'(MaxWidth);

   typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP, S_FIN} state_e;
   state_e state_q, state_d;

   logic [31:0] src_q, dst_q, dim_q;
   logic        irq_en_q, done_q, err_q, done_d, err_d;
   logic [1:0]  mode_q, j_mode_q;
   logic [7:0]  thresh_q, j_thresh_q;
   logic [31:0] j_src_q, j_dst_q, idx_q;
   logic [15:0] j_w_q, j_h_q, x_q, y_q;
   logic [2:0][2:0][7:0] win_q;   // [column][row], column 2 newest, row 2 current line
   logic [7:0]  lb1_mem [MaxWidth];
   logic [7:0]  lb2_mem [MaxWidth];
   logic [7:0]  lb1_rd_q, lb2_rd_q;
   logic        s_rvalid_q, s_rid_q;
   logic [31:0] s_rdata_q, rd_mux, cycles_rd;

   logic [2:0]  s_off;
   logic        s_wr, start_wr, cfg_ok, start_ok, start_bad, busy;
   logic        take_px, pix_done, set_done, set_err, last_px, out_due;
   logic [31:0] rd_addr, wr_addr;
   logic [7:0]  pix, res;
   logic [LbAw-1:0] lb_addr;

   assign s_off     = obi_sbr_req_i.addr[4:2];
   assign s_wr      = obi_sbr_req_i.req & obi_sbr_req_i.we;
   assign start_wr  = s_wr && (s_off == 3'd3) && obi_sbr_req_i.wdata[0];
   assign cfg_ok    = (dim_q[15:0] >= 16'd3) && (dim_q[31:16] >= 16'd3) && ({1'b0, dim_q[15:0]} <= MaxW17);
   assign start_ok  = start_wr && (state_q == S_IDLE) && cfg_ok;
   assign start_bad = start_wr && (state_q == S_IDLE) && !cfg_ok;
   assign busy      = (state_q != S_IDLE);
   assign last_px   = (x_q == j_w_q - 16'd1) && (y_q == j_h_q - 16'd1);
   assign out_due   = (x_q >= 16'd2) && (y_q >= 16'd2);
   assign rd_addr   = j_src_q + idx_q;
   // Output pixel is centred one column and one row behind the pixel just read.
   assign wr_addr   = j_dst_q + idx_q - {16'b0, j_w_q} - 32'd1;
   assign pix       = obi_mgr_rsp_i.rdata[{rd_addr[1:0], 3'b000} +: 8];
   assign lb_addr   = x_q[LbAw-1:0];
   assign interrupt_o = done_q & irq_en_q;

   // Sobel datapath on the registered window
   logic signed [10:0] px [3][3];
   logic signed [10:0] gx, gy;
   logic [10:0] ax, ay, m;
   logic [11:0] s;
   genvar gi;
   for (gi = 0; gi < 9; gi++) begin : g_px
      assign px[gi/3][gi%3] = $signed({3'b000, win_q[gi/3][gi%3]});
   end
   assign gx = px[2][0] + (px[2][1] <<< 1) + px[2][2] - px[0][0] - (px[0][1] <<< 1) - px[0][2];
   assign gy = px[0][2] + (px[1][2] <<< 1) + px[2][2] - px[0][0] - (px[1][0] <<< 1) - px[2][0];
   assign ax = gx[10] ? 11'(-gx) : 11'(gx);
   assign ay = gy[10] ? 11'(-gy) : 11'(gy);
   assign s  = {1'b0, ax} + {1'b0, ay};
   assign m  = s[11:1];

   function automatic logic [7:0] sat8(input logic [10:0] v);
      return (v > 11'd255) ? 8'hFF : v[7:0];
   endfunction

   always_comb begin
      res = 8'h00;
      case (j_mode_q)
         2'd0:    res = (m > {3'b000, j_thresh_q}) ? 8'hFF : 8'h00;
         2'd1:    res = sat8(m);
         2'd2:    res = sat8(ax);
         default: res = sat8(ay);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      take_px  = 1'b0;
      pix_done = 1'b0;
      set_done = 1'b0;
      set_err  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) state_d = S_RD_REQ;
            if (start_bad) begin
               set_done = 1'b1;
               set_err  = 1'b1;
            end
         end
         S_RD_REQ: if (obi_mgr_rsp_i.gnt) state_d = S_RD_RSP;
         S_RD_RSP: begin
            if (obi_mgr_rsp_i.rvalid) begin
               if (obi_mgr_rsp_i.err) begin
                  set_done = 1'b1;
                  set_err  = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  take_px = 1'b1;
                  if (out_due) begin
                     state_d = S_WR_REQ;
                  end else begin
                     pix_done = 1'b1;
                     state_d  = last_px ? S_FIN : S_RD_REQ;
                  end
               end
            end
         end
         S_WR_REQ: if (obi_mgr_rsp_i.gnt) state_d = S_WR_RSP;
         S_WR_RSP: begin
            if (obi_mgr_rsp_i.rvalid) begin
               if (obi_mgr_rsp_i.err) begin
                  set_done = 1'b1;
                  set_err  = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  pix_done = 1'b1;
                  state_d  = last_px ? S_FIN : S_RD_REQ;
               end
            end
         end
         S_FIN: begin
            set_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky status: a completion event in the same cycle as W1C keeps the bit set.
   always_comb begin
      done_d = done_q;
      err_d  = err_q;
      if (s_wr && (s_off == 3'd4)) begin
         if (obi_sbr_req_i.wdata[1]) done_d = 1'b0;
         if (obi_sbr_req_i.wdata[2]) err_d  = 1'b0;
      end
      if (set_done) done_d = 1'b1;
      if (set_err)  err_d  = 1'b1;
   end

   always_comb begin
      obi_mgr_req_o = '0;
      if (state_q == S_RD_REQ) begin
         obi_mgr_req_o.req  = 1'b1;
         obi_mgr_req_o.addr = {rd_addr[31:2], 2'b00};
      end else if (state_q == S_WR_REQ) begin
         obi_mgr_req_o.req   = 1'b1;
         obi_mgr_req_o.we    = 1'b1;
         obi_mgr_req_o.be    = 4'b0001 << wr_addr[1:0];
         obi_mgr_req_o.addr  = {wr_addr[31:2], 2'b00};
         obi_mgr_req_o.wdata = {4{res}};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         dim_q    <= '0;
         irq_en_q <= 1'b0;
         mode_q   <= '0;
         thresh_q <= ThreshReset;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         j_src_q  <= '0;
         j_dst_q  <= '0;
         j_w_q    <= '0;
         j_h_q    <= '0;
         j_mode_q <= '0;
         j_thresh_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         idx_q    <= '0;
         win_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (s_wr) begin
            case (s_off)
               3'd0: src_q <= obi_sbr_req_i.wdata;
               3'd1: dst_q <= obi_sbr_req_i.wdata;
               3'd2: dim_q <= obi_sbr_req_i.wdata;
               3'd3: begin
                  irq_en_q <= obi_sbr_req_i.wdata[1];
                  mode_q   <= obi_sbr_req_i.wdata[3:2];
                  thresh_q <= obi_sbr_req_i.wdata[15:8];
               end
               default: ;
            endcase
         end
         if (start_ok) begin
            j_src_q    <= src_q;
            j_dst_q    <= dst_q;
            j_w_q      <= dim_q[15:0];
            j_h_q      <= dim_q[31:16];
            j_mode_q   <= obi_sbr_req_i.wdata[3:2];
            j_thresh_q <= obi_sbr_req_i.wdata[15:8];
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
         end else if (pix_done) begin
            idx_q <= idx_q + 32'd1;
            if (x_q == j_w_q - 16'd1) begin
               x_q <= '0;
               y_q <= y_q + 16'd1;
            end else begin
               x_q <= x_q + 16'd1;
            end
         end
         if (take_px) begin
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= {pix, lb1_rd_q, lb2_rd_q};
         end
      end
   end

   // Line buffers: column x is read ahead during RD_REQ, so the old rows are ready at rvalid.
   always_ff @(posedge clk_i) begin
      if (take_px) begin
         lb1_mem[lb_addr] <= pix;
         lb2_mem[lb_addr] <= lb1_rd_q;
      end
      lb1_rd_q <= lb1_mem[lb_addr];
      lb2_rd_q <= lb2_mem[lb_addr];
   end

`ifdef SOBEL_STREAM_ACCEL_PERF_EN
   logic [31:0] cycles_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycles_q <= '0;
      end else if (start_ok) begin
         cycles_q <= '0;
      end else if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_q <= cycles_q + 32'd1;
      end
   end
   assign cycles_rd = cycles_q;
`else
   assign cycles_rd = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (s_off)
         3'd0: rd_mux = src_q;
         3'd1: rd_mux = dst_q;
         3'd2: rd_mux = dim_q;
         3'd3: rd_mux = {16'b0, thresh_q, 4'b0, mode_q, irq_en_q, 1'b0};
         3'd4: rd_mux = {29'b0, err_q, done_q, busy};
         3'd5: rd_mux = cycles_rd;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_rvalid_q <= 1'b0;
         s_rid_q    <= 1'b0;
         s_rdata_q  <= '0;
      end else begin
         s_rvalid_q <= obi_sbr_req_i.req;
         s_rid_q    <= obi_sbr_req_i.aid;
         s_rdata_q  <= (obi_sbr_req_i.req && !obi_sbr_req_i.we) ? rd_mux : 32'd0;
      end
   end

   always_comb begin
      obi_sbr_rsp_o        = '0;
      obi_sbr_rsp_o.gnt    = obi_sbr_req_i.req;
      obi_sbr_rsp_o.rvalid = s_rvalid_q;
      obi_sbr_rsp_o.rdata  = s_rdata_q;
      obi_sbr_rsp_o.rid    = s_rid_q;
   end

   logic unused_bits;
   assign unused_bits = ^{obi_sbr_req_i.be, obi_sbr_req_i.addr[31:5], obi_sbr_req_i.addr[1:0],
                          obi_mgr_rsp_i.rid};
endmodule

// File: tb/tb_sobel_stream_accel.sv
// Directed bench for sobel_stream_accel: register file, zero-wait/stalling memory model, write scoreboard.
module tb_sobel_stream_accel;
   import sobel_stream_accel_pkg::*;
   localparam int MW = 640;

   logic clk = 1'b0;
   logic rst;
   mgr_obi_req_t sreq;
   mgr_obi_rsp_t srsp;
   sbr_obi_req_t mreq;
   sbr_obi_rsp_t mrsp;
   logic irq;

   always #5 clk = ~clk;

   sobel_stream_accel #(.MaxWidth(MW), .ThreshReset(8'd128)) dut (
      .clk_i(clk), .rst_i(rst),
      .obi_sbr_req_i(sreq), .obi_sbr_rsp_o(srsp),
      .obi_mgr_req_o(mreq), .obi_mgr_rsp_i(mrsp),
      .interrupt_o(irq)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   logic [31:0] rd_q[$];
   logic [7:0] mem [0:16383];
   int n_checks = 0;
   int n_fail = 0;

   // Memory model, owned by this block only
   logic m_gnt;
   logic m_rvalid = 1'b0, m_err = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [13:0] m_a;
   int rd_seen = 0, wait_cnt = 0, stall_cycles = 0, req_cycles = 0;
   int stall_at = -1, stall_len = 0, err_at = -1;
   logic prev_stall = 1'b0, unstable = 1'b0;
   logic [68:0] prev_a = '0;

   assign m_a  = mreq.addr[13:0];
   assign mrsp = '{gnt: m_gnt, rvalid: m_rvalid, rdata: m_rdata, rid: 1'b0, err: m_err};
   always_comb m_gnt = mreq.req && !(!mreq.we && (rd_seen == stall_at) && (wait_cnt < stall_len));

   always @(posedge clk) begin
      m_rvalid   <= 1'b0;
      m_err      <= 1'b0;
      m_rdata    <= '0;
      prev_stall <= mreq.req && !m_gnt;
      prev_a     <= {mreq.we, mreq.be, mreq.addr, mreq.wdata};
      if (mreq.req && prev_stall && ({mreq.we, mreq.be, mreq.addr, mreq.wdata} !== prev_a))
         unstable <= 1'b1;
      if (mreq.req) req_cycles <= req_cycles + 1;
      if (mreq.req && !m_gnt) begin
         wait_cnt     <= wait_cnt + 1;
         stall_cycles <= stall_cycles + 1;
      end else if (mreq.req) begin
         wait_cnt <= 0;
         m_rvalid <= 1'b1;
         if (mreq.we) begin
            obs_q.push_back('{addr: mreq.addr, be: mreq.be, wdata: mreq.wdata});
         end else begin
            rd_q.push_back(mreq.addr);
            m_rdata <= {mem[m_a + 14'd3], mem[m_a + 14'd2], mem[m_a + 14'd1], mem[m_a]};
            m_err   <= (rd_seen == err_at);
            rd_seen <= rd_seen + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
         $error("%s observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic reg_wr(input logic [2:0] off, input logic [31:0] d);
      @(negedge clk);
      sreq.req = 1'b1; sreq.we = 1'b1; sreq.be = 4'hF;
      sreq.addr = {27'b0, off, 2'b00}; sreq.wdata = d;
      @(negedge clk);
      sreq.req = 1'b0; sreq.we = 1'b0;
   endtask

   task automatic reg_rd(input logic [2:0] off, output logic [31:0] d);
      @(negedge clk);
      sreq.req = 1'b1; sreq.we = 1'b0; sreq.addr = {27'b0, off, 2'b00};
      @(negedge clk);
      sreq.req = 1'b0;
      d = srsp.rdata;
   endtask

   task automatic wait_idle();
      logic [31:0] st;
      logic to;
      to = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         reg_rd(3'd4, st);
         if (st[0] == 1'b0) begin
            to = 1'b0;
            break;
         end
      end
      check("job_timeout", 128'(to), 128'(0));
   endtask

   function automatic logic [7:0] ref_out(input int src, input int w, input int x, input int y,
                                          input int mode, input int thr);
      int p[3][3];
      int gx, gy, ax, ay, mm;
      for (int dx = 0; dx < 3; dx++)
         for (int dy = 0; dy < 3; dy++)
            p[dx][dy] = int'(mem[(src + (y - 1 + dy) * w + (x - 1 + dx)) & 16383]);
      gx = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      gy = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mm = (ax + ay) / 2;
      case (mode)
         0:       return (mm > thr) ? 8'hFF : 8'h00;
         1:       return (mm > 255) ? 8'hFF : 8'(mm);
         2:       return (ax > 255) ? 8'hFF : 8'(ax);
         default: return (ay > 255) ? 8'hFF : 8'(ay);
      endcase
   endfunction

   task automatic push_exp(input logic [31:0] a, input logic [7:0] v);
      exp_q.push_back('{addr: {a[31:2], 2'b00}, be: 4'b0001 << a[1:0], wdata: {4{v}}});
   endtask

   task automatic push_model(input int src, input int dst, input int w, input int h,
                             input int mode, input int thr);
      for (int y = 2; y < h; y++)
         for (int x = 2; x < w; x++)
            push_exp(32'(dst + (y - 1) * w + (x - 1)), ref_out(src, w, x - 1, y - 1, mode, thr));
   endtask

   task automatic start_job(input int src, input int dst, input int w, input int h,
                            input int mode, input int thr, input int ien);
      reg_wr(3'd0, 32'(src));
      reg_wr(3'd1, 32'(dst));
      reg_wr(3'd2, {16'(h), 16'(w)});
      reg_wr(3'd3, 32'((thr << 8) | (mode << 2) | (ien << 1) | 1));
   endtask

   // Runs a valid job and compares every read address and every write against the scoreboard.
   task automatic run_job(input string name, input int src, input int dst, input int w, input int h,
                          input int mode, input int thr, input int ien);
      int rb, ob, nw;
      logic [31:0] st;
      wr_t e;
      rb = rd_q.size();
      ob = obs_q.size();
      start_job(src, dst, w, h, mode, thr, ien);
      wait_idle();
      nw = obs_q.size() - ob;
      $display("job %s: %0dx%0d mode %0d reads %0d writes %0d", name, w, h, mode, rd_q.size() - rb, nw);
      check({name, "_reads"}, 128'(rd_q.size() - rb), 128'(w * h));
      for (int i = 0; i < w * h && rb + i < rd_q.size(); i++)
         check({name, "_rd_addr"}, 128'(rd_q[rb + i]), 128'((src + i) & ~3));
      check({name, "_writes"}, 128'(nw), 128'(exp_q.size()));
      for (int i = 0; i < nw && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         check({name, "_wr"}, 128'(obs_q[ob + i]), 128'(e));
      end
      exp_q.delete();
      reg_rd(3'd4, st);
      check({name, "_status"}, 128'(st[2:0]), 128'(3'b010));
   endtask

   initial begin
      logic [31:0] rd;
      int r0, rb, ob, sc0;
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      sreq = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mgr_req", 128'(mreq), 128'(0));
      check("rst_sbr_rsp", 128'(srsp), 128'(0));
      check("rst_irq", 128'(irq), 128'(0));
      rst = 1'b0;
      reg_rd(3'd3, rd); check("rst_ctrl", 128'(rd), 128'(32'h0000_8000));
      reg_rd(3'd2, rd); check("rst_dim", 128'(rd), 128'(0));
      reg_rd(3'd4, rd); check("rst_status", 128'(rd), 128'(0));
      reg_wr(3'd6, 32'hDEAD_BEEF);
      reg_rd(3'd6, rd); check("unmapped_rd", 128'(rd), 128'(0));

      // 4x4, column 3 bright, MODE0: explicit expected bytes at DST offsets 5,6,9,10
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) mem[16'h1000 + y * 4 + x] = (x == 3) ? 8'hFF : 8'h00;
      push_exp(32'h2005, 8'h00);
      push_exp(32'h2006, 8'hFF);
      push_exp(32'h2009, 8'h00);
      push_exp(32'h200A, 8'hFF);
      run_job("m0", 32'h1000, 32'h2000, 4, 4, 0, 128, 1);
      check("irq_after_done", 128'(irq), 128'(1));
      reg_rd(3'd5, rd);
`ifdef SOBEL_STREAM_ACCEL_PERF_EN
      check("cycles", 128'(rd), 128'(41));
`else
      check("cycles", 128'(rd), 128'(0));
`endif
      reg_wr(3'd4, 32'h2);
      check("irq_after_w1c", 128'(irq), 128'(0));

      for (int md = 1; md < 4; md++) begin
         push_model(32'h1000, 32'h2000, 4, 4, md, 128);
         run_job($sformatf("m%0d", md), 32'h1000, 32'h2000, 4, 4, md, 128, 0);
         reg_wr(3'd4, 32'h2);
      end

      for (int i = 0; i < 16; i++) mem[16'h1100 + i] = 8'h40;
      for (int md = 0; md < 4; md++) begin
         for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'h2100 + 32'(i / 2) * 4 + 4,
                                                        be: 4'b0010 << (i % 2), wdata: 32'h0});
         run_job($sformatf("flat%0d", md), 32'h1100, 32'h2100, 4, 4, md, 128, 0);
         reg_wr(3'd4, 32'h2);
      end

      // Unaligned source, 3x3: first read word 0x1000, single write to 0x2007 (lane 3)
      for (int i = 0; i < 9; i++) mem[16'h1002 + i] = 8'(i * 29 + 7);
      push_model(32'h1002, 32'h2003, 3, 3, 1, 128);
      rb = rd_q.size();
      run_job("unal", 32'h1002, 32'h2003, 3, 3, 1, 128, 0);
      check("unal_first_rd", 128'(rd_q[rb]), 128'(32'h1000));
      reg_wr(3'd4, 32'h2);

      // Invalid geometry: no traffic, ERR and DONE at once
      r0 = req_cycles;
      start_job(32'h1000, 32'h2000, 2, 4, 0, 128, 0);
      repeat (4) @(negedge clk);
      check("w2_no_req", 128'(req_cycles), 128'(r0));
      reg_rd(3'd4, rd); check("w2_status", 128'(rd[2:0]), 128'(3'b110));
      reg_wr(3'd4, 32'h6);
      r0 = req_cycles;
      start_job(32'h1000, 32'h2000, MW + 1, 3, 0, 128, 0);
      repeat (4) @(negedge clk);
      check("wmax1_no_req", 128'(req_cycles), 128'(r0));
      reg_rd(3'd4, rd); check("wmax1_status", 128'(rd[2:0]), 128'(3'b110));
      reg_wr(3'd4, 32'h6);

      // Widest image
      for (int i = 0; i < MW * 3; i++) mem[i] = 8'($urandom);
      push_model(0, 32'h3000, MW, 3, 1, 128);
      run_job("wmax", 0, 32'h3000, MW, 3, 1, 128, 0);
      reg_wr(3'd4, 32'h2);

      // Stall the 5th read for 3 cycles and return err on it
      rb = rd_q.size();
      ob = obs_q.size();
      sc0 = stall_cycles;
      stall_at = rd_seen + 4;
      stall_len = 3;
      err_at = rd_seen + 4;
      start_job(32'h1000, 32'h2000, 4, 4, 0, 128, 0);
      wait_idle();
      $display("job err: reads %0d writes %0d stall %0d", rd_q.size() - rb, obs_q.size() - ob, stall_cycles - sc0);
      check("err_reads", 128'(rd_q.size() - rb), 128'(5));
      check("err_rd5_addr", 128'(rd_q[rb + 4]), 128'(32'h1004));
      check("err_writes", 128'(obs_q.size() - ob), 128'(0));
      check("err_stall_cycles", 128'(stall_cycles - sc0), 128'(3));
      check("err_stable", 128'(unstable), 128'(0));
      reg_rd(3'd4, rd); check("err_status", 128'(rd[2:0]), 128'(3'b110));
      stall_at = -1;
      err_at = -1;
      reg_wr(3'd4, 32'h6);

      // Reset in the middle of a job
      start_job(32'h1000, 32'h2000, 4, 4, 0, 128, 1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_mgr_req", 128'(mreq), 128'(0));
      check("midrst_sbr_rsp", 128'(srsp), 128'(0));
      check("midrst_irq", 128'(irq), 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      reg_rd(3'd4, rd); check("midrst_status", 128'(rd), 128'(0));
      reg_rd(3'd3, rd); check("midrst_ctrl", 128'(rd), 128'(32'h0000_8000));
      r0 = req_cycles;
      repeat (4) @(negedge clk);
      check("midrst_idle", 128'(req_cycles), 128'(r0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
